uart_packet_assembler: RTL and testbench
========================================

UART_PACKET_ASSEMBLER -- requirements
Module: uart_packet_assembler

Interface
REQ-001 Parameter: UARTMHZ, default 50000000, peripheral clock frequency in Hz.
REQ-002 Parameter: BAUDRATE, default 115200, line baud rate.
REQ-003 Parameter: TIMEOUT_BYTES, default 4, inter-byte gap (in byte times) that aborts a partial packet.
REQ-004 Port: iCLOCK  input  1  single system clock; all logic on rising edge.
REQ-005 Port: iNRESET  input  1  reset, asynchronous, active-low.
REQ-006 Port: iRXDATA  input  8  received byte from the UART receive stage.
REQ-007 Port: iRXDONE  input  1  one-cycle strobe; iRXDATA is valid in this cycle.
REQ-008 Port: oOPCODE  output  16  assembled opcode (packet bytes 0-1).
REQ-009 Port: oADDR  output  16  assembled memory address (packet bytes 2-3).
REQ-010 Port: oDATA  output  32  assembled data word (packet bytes 4-7).
REQ-011 Port: oVALID  output  1  packet available; held until accepted.
REQ-012 Port: iREADY  input  1  consumer accepts the packet when high with oVALID.
REQ-013 Port: oOVERRUN  output  1  one-cycle pulse: byte dropped while a packet was pending.
REQ-014 Port: oTIMEOUT  output  1  one-cycle pulse: partial packet discarded by gap timeout.

Function
REQ-015 Packet SHALL be 8 bytes, big-endian: byte0 = oOPCODE[15:8], byte1 = oOPCODE[7:0], byte2 = oADDR[15:8], byte3 = oADDR[7:0], byte4 = oDATA[31:24] through byte7 = oDATA[7:0].
REQ-016 FSM states SHALL be IDLE, COLLECT, HOLD.
REQ-017 IDLE: iRXDONE stores byte0, sets byte count to 1, moves to COLLECT.
REQ-018 COLLECT: each iRXDONE stores the byte at the current index and increments the count; the 8th byte moves to HOLD.
REQ-019 oVALID SHALL rise in the cycle after the iRXDONE of byte7 (1-cycle latency); outputs SHALL be registered and stable while oVALID is high.
REQ-020 HOLD: oVALID && iREADY completes the handshake; oVALID SHALL deassert the next cycle and the FSM returns to IDLE.
REQ-021 HOLD with iRXDONE and no iREADY: byte discarded, oOVERRUN pulses 1 cycle, packet retained.
REQ-022 HOLD with iRXDONE and iREADY in the same cycle: handshake completes, the byte becomes byte0 of the next packet, state goes to COLLECT with count 1, no oOVERRUN.
REQ-023 Gap counter SHALL clear on every iRXDONE and count only in COLLECT; at TIMEOUT_BYTES*(UARTMHZ/BAUDRATE*10) cycles (17360 at defaults) the partial packet is discarded, oTIMEOUT pulses 1 cycle, and the state goes to IDLE.
REQ-024 iRXDONE in the same cycle as the timeout SHALL win: the byte is stored and no timeout occurs.
REQ-025 Gap counter width SHALL be sized from the parameters and SHALL saturate, never wrap.
REQ-026 In IDLE and HOLD the gap counter SHALL be held at 0.

Reset
REQ-027 While iNRESET is low: state IDLE, count 0, gap counter 0, oOPCODE/oADDR/oDATA = 0, oVALID/oOVERRUN/oTIMEOUT = 0.
REQ-028 Reset mid-packet or in HOLD SHALL discard all buffered bytes; the first iRXDONE after release is byte0.

Structure
REQ-029 A shared package SHALL hold the state encoding, the byte-count constants (OPCDBYTE=2, ADDRBYTE=2, DATABYTE=4, BYTES=8), and the byte-time calculation.
REQ-030 One sub-module, uart_gap_timer (clear/enable inputs, expiry pulse output), SHALL implement the timeout counter; the rest is a single FSM/datapath.

Verification
REQ-031 Send bytes 12 34 AB CD DE AD BE EF with iREADY high -> one oVALID cycle, oOPCODE=1234, oADDR=ABCD, oDATA=DEADBEEF.
REQ-032 Same packet with iREADY low for 50 cycles, then a 9th byte 55 arrives -> oOVERRUN pulses once, outputs unchanged, oVALID stays high until iREADY.
REQ-033 Send 3 bytes, then idle 17360 cycles -> oTIMEOUT pulses once; the next 8 bytes form a correct packet.
REQ-034 In HOLD, assert iREADY in the same cycle as iRXDONE(0x01) -> handshake completes, 0x01 becomes the new oOPCODE[15:8], no oOVERRUN.
REQ-035 Assert iNRESET low after byte 5 -> all outputs 0; after release, a fresh 8-byte packet assembles correctly.
REQ-036 Chain behind the UART receive stage and transmit model at 115200 baud -> back-to-back packets decode with no timeout or overrun.

Source files
------------

// File: rtl/uart_packet_assembler_pkg.sv
// Shared definitions for the UART packet assembler.
//   state_t   : assembler FSM states (IDLE, COLLECT, HOLD)
//   OPCDBYTE / ADDRBYTE / DATABYTE / BYTES : packet field sizes in bytes
//   CNTW      : width of the received-byte counter
//   byte_time : clock cycles per 10-bit UART frame (start + 8 data + stop)
package uart_packet_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int unsigned OPCDBYTE = 2;
  localparam int unsigned ADDRBYTE = 2;
  localparam int unsigned DATABYTE = 4;
  localparam int unsigned BYTES    = OPCDBYTE + ADDRBYTE + DATABYTE;
  localparam int unsigned CNTW     = $clog2(BYTES + 1);

  function automatic int unsigned byte_time(input int unsigned clk_hz,
                                            input int unsigned baud);
    return (clk_hz / baud) * 10;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : forces the count to zero (has priority over enable)
//   enable     : count one cycle of gap
//   expire     : one-cycle pulse in the cycle the count reaches LIMIT
// The count saturates at LIMIT, so a stalled consumer of the pulse never
// sees it wrap around and fire again.
module uart_gap_timer #(
  parameter int unsigned LIMIT = 17360
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (enable) begin
        if (cnt != TOP) cnt <= cnt + W'(1);
        if (cnt == LAST) expire <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_packet_assembler.sv
// Assembles 8 received UART bytes into a big-endian command packet.
//   iCLOCK, iNRESET : clock, asynchronous active-low reset
//   iRXDATA/iRXDONE : byte and its one-cycle strobe from the UART receiver
//   oOPCODE/oADDR/oDATA : packet bytes 0-1 / 2-3 / 4-7
//   oVALID/iREADY   : packet handshake, oVALID held until accepted
//   oOVERRUN        : pulse, byte dropped while a packet was pending
//   oTIMEOUT        : pulse, partial packet discarded after an inter-byte gap
module uart_packet_assembler
  import uart_packet_assembler_pkg::*;
#(
  parameter int unsigned UARTMHZ       = 50000000,
  parameter int unsigned BAUDRATE      = 115200,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic        iCLOCK,
  input  logic        iNRESET,
  input  logic [7:0]  iRXDATA,
  input  logic        iRXDONE,
  output logic [15:0] oOPCODE,
  output logic [15:0] oADDR,
  output logic [31:0] oDATA,
  output logic        oVALID,
  input  logic        iREADY,
  output logic        oOVERRUN,
  output logic        oTIMEOUT
);

  localparam int unsigned GAP_LIMIT = TIMEOUT_BYTES * byte_time(UARTMHZ, BAUDRATE);

  state_t              state, state_d;
  logic [CNTW-1:0]     count, count_d;
  logic [CNTW-1:0]     wr_idx;
  logic                wr_en;
  logic [8*BYTES-1:0]  pkt;
  logic                valid, valid_d;
  logic                overrun, overrun_d;
  logic                timeout, timeout_d;
  logic                gap_clear, gap_en, gap_expire;

  assign gap_en    = (state == COLLECT);
  assign gap_clear = iRXDONE || (state != COLLECT);

  uart_gap_timer #(
    .LIMIT(GAP_LIMIT)
  ) u_gap_timer (
    .clk    (iCLOCK),
    .rst_n  (iNRESET),
    .clear  (gap_clear),
    .enable (gap_en),
    .expire (gap_expire)
  );

  always_ff @(posedge iCLOCK or negedge iNRESET) begin
    if (!iNRESET) begin
      state   <= IDLE;
      count   <= '0;
      pkt     <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      valid   <= valid_d;
      overrun <= overrun_d;
      timeout <= timeout_d;
      // Byte index 0 lands in the most significant byte of the packet.
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (wr_en && (wr_idx == CNTW'(i))) pkt[8*(BYTES-1-i) +: 8] <= iRXDATA;
      end
    end
  end

  always_comb begin
    state_d   = state;
    count_d   = count;
    valid_d   = valid;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    case (state)
      IDLE: begin
        if (iRXDONE) begin
          wr_en   = 1'b1;
          count_d = CNTW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // A byte arriving with the expiry pulse is kept; the gap ended in time.
        if (iRXDONE) begin
          wr_en   = 1'b1;
          wr_idx  = count;
          count_d = count + CNTW'(1);
          if (count == CNTW'(BYTES - 1)) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end else if (gap_expire) begin
          count_d   = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        if (iREADY) begin
          valid_d = 1'b0;
          if (iRXDONE) begin
            // Handshake and the next packet's first byte in the same cycle.
            wr_en   = 1'b1;
            count_d = CNTW'(1);
            state_d = COLLECT;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else if (iRXDONE) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign oOPCODE  = pkt[8*BYTES-1 -: 8*OPCDBYTE];
  assign oADDR    = pkt[8*(ADDRBYTE+DATABYTE)-1 -: 8*ADDRBYTE];
  assign oDATA    = pkt[8*DATABYTE-1:0];
  assign oVALID   = valid;
  assign oOVERRUN = overrun;
  assign oTIMEOUT = timeout;

endmodule

// File: tb/tb_uart_packet_assembler.sv
module tb_uart_packet_assembler;

  localparam int BYTE_TIME = 4340;   // (50e6/115200 truncated) * 10
  localparam int GAP       = 17360;  // 4 byte times

  logic        iCLOCK = 1'b0;
  logic        iNRESET;
  logic [7:0]  iRXDATA;
  logic        iRXDONE;
  logic        iREADY;
  logic [15:0] oOPCODE;
  logic [15:0] oADDR;
  logic [31:0] oDATA;
  logic        oVALID;
  logic        oOVERRUN;
  logic        oTIMEOUT;

  int vectors = 0;
  int miscompares = 0;
  int ev_to = 0;
  int ev_ov = 0;
  logic [7:0] pb [8];

  always #5 iCLOCK = ~iCLOCK;

  uart_packet_assembler #(
    .UARTMHZ(50000000),
    .BAUDRATE(115200),
    .TIMEOUT_BYTES(4)
  ) dut (
    .iCLOCK(iCLOCK), .iNRESET(iNRESET), .iRXDATA(iRXDATA), .iRXDONE(iRXDONE),
    .oOPCODE(oOPCODE), .oADDR(oADDR), .oDATA(oDATA), .oVALID(oVALID),
    .iREADY(iREADY), .oOVERRUN(oOVERRUN), .oTIMEOUT(oTIMEOUT)
  );

  // Reference model: the packet is just the 8 bytes concatenated in arrival order.
  function automatic logic [63:0] model_pkt();
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], pb[i]};
    return r;
  endfunction

  task automatic tick();
    @(negedge iCLOCK);
  endtask

  task automatic strobe(input logic [7:0] b);
    iRXDATA = b;
    iRXDONE = 1'b1;
    tick();
    iRXDONE = 1'b0;
    iRXDATA = 8'($urandom);
  endtask

  task automatic idle_watch(input int n);
    repeat (n) begin
      tick();
      if (oTIMEOUT) ev_to++;
      if (oOVERRUN) ev_ov++;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) pb[i] = 8'($urandom);
  endtask

  task automatic send_pb(input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++) begin
      strobe(pb[i]);
      if (i != last) repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  task automatic test_reset();
    iNRESET = 1'b0; iRXDONE = 1'b0; iRXDATA = 8'h00; iREADY = 1'b0;
    tick(); tick();
    vectors++;
    if ({oOPCODE, oADDR, oDATA, oVALID, oOVERRUN, oTIMEOUT} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h, expected 0", {oOPCODE, oADDR, oDATA, oVALID, oOVERRUN, oTIMEOUT});
    end
    iNRESET = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pb[0] = 8'h12; pb[1] = 8'h34; pb[2] = 8'hAB; pb[3] = 8'hCD;
    pb[4] = 8'hDE; pb[5] = 8'hAD; pb[6] = 8'hBE; pb[7] = 8'hEF;
    iREADY = 1'b1;
    send_pb(0, 6, 3);
    vectors++;
    if (oVALID !== 1'b0) begin
      miscompares++; $display("FAIL basic_early_valid: got %b, expected 0", oVALID);
    end
    strobe(pb[7]);
    vectors++;
    if (oVALID !== 1'b1) begin
      miscompares++; $display("FAIL basic_valid: got %b, expected 1", oVALID);
    end
    vectors++;
    if ({oOPCODE, oADDR, oDATA} !== 64'h1234ABCD_DEADBEEF) begin
      miscompares++; $display("FAIL basic_packet: got %h, expected 1234abcddeadbeef", {oOPCODE, oADDR, oDATA});
    end
    tick();
    vectors++;
    if (oVALID !== 1'b0) begin
      miscompares++; $display("FAIL basic_valid_drop: got %b, expected 0", oVALID);
    end
    iREADY = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] snap;
    repeat (4) begin
      fill_random();
      iREADY = 1'b0;
      send_pb(0, 7, 6);
      vectors++;
      if (oVALID !== 1'b1 || {oOPCODE, oADDR, oDATA} !== model_pkt()) begin
        miscompares++;
        $display("FAIL random_packet: got v=%b %h, expected v=1 %h", oVALID, {oOPCODE, oADDR, oDATA}, model_pkt());
      end
      snap = model_pkt();
      repeat ($urandom_range(1, 10)) tick();
      vectors++;
      if (oVALID !== 1'b1 || {oOPCODE, oADDR, oDATA} !== snap) begin
        miscompares++;
        $display("FAIL random_hold: got v=%b %h, expected v=1 %h", oVALID, {oOPCODE, oADDR, oDATA}, snap);
      end
      iREADY = 1'b1;
      tick();
      vectors++;
      if (oVALID !== 1'b0) begin
        miscompares++; $display("FAIL random_accept: got %b, expected 0", oVALID);
      end
      iREADY = 1'b0;
    end
  endtask

  task automatic test_overrun();
    int lost = 0;
    pb[0] = 8'h12; pb[1] = 8'h34; pb[2] = 8'hAB; pb[3] = 8'hCD;
    pb[4] = 8'hDE; pb[5] = 8'hAD; pb[6] = 8'hBE; pb[7] = 8'hEF;
    iREADY = 1'b0;
    send_pb(0, 7, 2);
    repeat (50) begin
      tick();
      if (oVALID !== 1'b1 || oOVERRUN !== 1'b0) lost++;
    end
    vectors++;
    if (lost !== 0) begin
      miscompares++; $display("FAIL overrun_wait: got %0d bad cycles, expected 0", lost);
    end
    strobe(8'h55);
    vectors++;
    if (oOVERRUN !== 1'b1) begin
      miscompares++; $display("FAIL overrun_pulse: got %b, expected 1", oOVERRUN);
    end
    tick();
    vectors++;
    if (oOVERRUN !== 1'b0 || oVALID !== 1'b1) begin
      miscompares++; $display("FAIL overrun_after: got ovr=%b v=%b, expected ovr=0 v=1", oOVERRUN, oVALID);
    end
    vectors++;
    if ({oOPCODE, oADDR, oDATA} !== 64'h1234ABCD_DEADBEEF) begin
      miscompares++; $display("FAIL overrun_data: got %h, expected 1234abcddeadbeef", {oOPCODE, oADDR, oDATA});
    end
    iREADY = 1'b1;
    tick();
    vectors++;
    if (oVALID !== 1'b0) begin
      miscompares++; $display("FAIL overrun_accept: got %b, expected 0", oVALID);
    end
    iREADY = 1'b0;
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int at = -1;
    iREADY = 1'b1;
    fill_random();
    send_pb(0, 2, 2);
    for (int k = 1; k <= GAP + 10; k++) begin
      tick();
      if (oTIMEOUT) begin
        pulses++;
        if (at < 0) at = k;
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++; $display("FAIL timeout_count: got %0d pulses, expected 1", pulses);
    end
    vectors++;
    if (at < GAP || at > GAP + 2) begin
      miscompares++; $display("FAIL timeout_time: got cycle %0d, expected %0d..%0d", at, GAP, GAP + 2);
    end
    fill_random();
    iREADY = 1'b0;
    send_pb(0, 7, 3);
    vectors++;
    if (oVALID !== 1'b1 || {oOPCODE, oADDR, oDATA} !== model_pkt()) begin
      miscompares++;
      $display("FAIL timeout_next_packet: got v=%b %h, expected v=1 %h", oVALID, {oOPCODE, oADDR, oDATA}, model_pkt());
    end
    iREADY = 1'b1;
    tick();
    iREADY = 1'b0;
  endtask

  task automatic test_same_cycle();
    iREADY = 1'b0;
    fill_random();
    send_pb(0, 7, 2);
    fill_random();
    pb[0] = 8'h01;
    iREADY = 1'b1;
    strobe(pb[0]);
    iREADY = 1'b0;
    vectors++;
    if (oVALID !== 1'b0 || oOVERRUN !== 1'b0) begin
      miscompares++; $display("FAIL same_cycle_handshake: got v=%b ovr=%b, expected v=0 ovr=0", oVALID, oOVERRUN);
    end
    send_pb(1, 7, 2);
    vectors++;
    if (oVALID !== 1'b1 || oOPCODE[15:8] !== 8'h01) begin
      miscompares++; $display("FAIL same_cycle_byte0: got v=%b op_hi=%h, expected v=1 op_hi=01", oVALID, oOPCODE[15:8]);
    end
    vectors++;
    if ({oOPCODE, oADDR, oDATA} !== model_pkt()) begin
      miscompares++; $display("FAIL same_cycle_packet: got %h, expected %h", {oOPCODE, oADDR, oDATA}, model_pkt());
    end
    iREADY = 1'b1;
    tick();
    iREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int pass = 0; pass < 2; pass++) begin
      iREADY = 1'b0;
      fill_random();
      if (pass == 0) send_pb(0, 4, 2);  // mid-packet, after byte 5
      else send_pb(0, 7, 2);            // while holding a finished packet
      iNRESET = 1'b0;
      #1;
      vectors++;
      if ({oOPCODE, oADDR, oDATA, oVALID, oOVERRUN, oTIMEOUT} !== 67'd0) begin
        miscompares++;
        $display("FAIL reset_mid_p%0d: got %h, expected 0", pass, {oOPCODE, oADDR, oDATA, oVALID, oOVERRUN, oTIMEOUT});
      end
      tick();
      iNRESET = 1'b1;
      tick();
      fill_random();
      send_pb(0, 7, 2);
      vectors++;
      if (oVALID !== 1'b1 || {oOPCODE, oADDR, oDATA} !== model_pkt()) begin
        miscompares++;
        $display("FAIL reset_fresh_p%0d: got v=%b %h, expected v=1 %h", pass, oVALID, {oOPCODE, oADDR, oDATA}, model_pkt());
      end
      iREADY = 1'b1;
      tick();
    end
    iREADY = 1'b0;
  endtask

  task automatic test_back_to_back();
    ev_to = 0;
    ev_ov = 0;
    iREADY = 1'b1;
    fill_random();
    send_pb(0, 3, 1);
    for (int i = 4; i < 8; i++) begin
      idle_watch(BYTE_TIME - 1);
      strobe(pb[i]);
    end
    vectors++;
    if (oVALID !== 1'b1 || {oOPCODE, oADDR, oDATA} !== model_pkt()) begin
      miscompares++;
      $display("FAIL b2b_packet1: got v=%b %h, expected v=1 %h", oVALID, {oOPCODE, oADDR, oDATA}, model_pkt());
    end
    fill_random();
    for (int i = 0; i < 4; i++) begin
      idle_watch(BYTE_TIME - 1);
      strobe(pb[i]);
    end
    send_pb(4, 7, 1);
    vectors++;
    if (oVALID !== 1'b1 || {oOPCODE, oADDR, oDATA} !== model_pkt()) begin
      miscompares++;
      $display("FAIL b2b_packet2: got v=%b %h, expected v=1 %h", oVALID, {oOPCODE, oADDR, oDATA}, model_pkt());
    end
    idle_watch(2);
    vectors++;
    if (ev_to !== 0 || ev_ov !== 0) begin
      miscompares++; $display("FAIL b2b_events: got to=%0d ovr=%0d, expected 0 0", ev_to, ev_ov);
    end
    iREADY = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_overrun();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
